// File: rtl/rv_uart_pkg.sv
// Shared register offsets, STATUS bit positions and FSM state type for the console UART.
// Build option UART_TX_PARITY_EN adds a PARITY state (even parity) between DATA and STOP.
package rv_uart_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd4,
`endif
    ST_STOP   = 3'd3
  } uart_tx_state_t;

  // Clamp a divider write so a bit always lasts at least one clock.
  function automatic logic [15:0] clamp_div(input logic [15:0] v);
    return (v < 16'd2) ? 16'd1 : v;
  endfunction

endpackage

// File: rtl/rv_uart_tx_fifo.sv
// Synchronous TX FIFO: combinational read of head, push/pop take effect at the clock edge.
// A push while full is still accepted when a pop happens in the same cycle; otherwise it is dropped.
module rv_uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             push_ok_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_ok;
  logic             push_ok;

  always_comb begin
    full_o  = (count_q == CW'(DEPTH));
    empty_o = (count_q == '0);
    count_o = count_q;
    rdata_o = mem_q[rd_ptr_q];
    pop_ok  = pop_i && !empty_o;
    push_ok = push_i && (!full_o || pop_ok);
    push_ok_o = push_ok;

    // DEPTH is a power of two, so the pointers wrap naturally.
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/rv_uart_tx.sv
// Console UART transmitter on the dm_* bus: TX FIFO + 8N1 serialiser (8E1 with UART_TX_PARITY_EN), 1-cycle registered loads.
// No bus backpressure: writes to a full FIFO are dropped and flagged in sticky STATUS.overflow.
module rv_uart_tx
  import rv_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0010_0000,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_write_i,
  output logic [31:0] dm_data_l_o,
  output logic        uart_txd_o
);

  localparam int CW = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;

  logic          reg_hit;
  logic [1:0]    reg_off;
  logic          reg_wr;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_push_ok;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic [7:0]    count8;
  logic [15:0]   div_wr_val;
  logic          unused_bus_bits;

  logic          ovf_q, ovf_d;
  logic [15:0]   div_q, div_d;
  logic [31:0]   data_l_q, data_l_d;

  uart_tx_state_t state_q, state_d;
  logic [15:0]   timer_q, timer_d;
  logic [15:0]   bdiv_q, bdiv_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    byte_q, byte_d;
  logic          txd_q, txd_d;

  rv_uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .push_i    (fifo_push),
    .wdata_i   (dm_data_s_i[7:0]),
    .pop_i     (fifo_pop),
    .rdata_o   (fifo_rdata),
    .push_ok_o (fifo_push_ok),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign unused_bus_bits = ^{dm_data_s_i[31:16], dm_data_select_i[3:2], dm_addr_i[1:0]};

  // Bus decode, register writes and the registered load path.
  always_comb begin
    reg_hit   = (dm_addr_i[31:4] == BASE_ADDR[31:4]);
    reg_off   = dm_addr_i[3:2];
    reg_wr    = reg_hit && dm_write_i;
    fifo_push = reg_wr && (reg_off == REG_TXDATA) && dm_data_select_i[0];
    count8    = 8'(fifo_count);

    ovf_d = ovf_q;
    if (fifo_push && !fifo_push_ok) begin
      ovf_d = 1'b1;
    end else if (reg_wr && (reg_off == REG_STATUS) && dm_data_select_i[0]
                 && dm_data_s_i[STAT_OVF]) begin
      ovf_d = 1'b0;
    end

    div_wr_val = div_q;
    if (dm_data_select_i[0]) div_wr_val[7:0]  = dm_data_s_i[7:0];
    if (dm_data_select_i[1]) div_wr_val[15:8] = dm_data_s_i[15:8];
    div_d = div_q;
    if (reg_wr && (reg_off == REG_DIV) && (|dm_data_select_i[1:0])) begin
      div_d = clamp_div(div_wr_val);
    end

    data_l_d = '0;
    if (reg_hit) begin
      case (reg_off)
        REG_STATUS: begin
          data_l_d[STAT_FULL]  = fifo_full;
          data_l_d[STAT_EMPTY] = fifo_empty;
          data_l_d[STAT_BUSY]  = (state_q != ST_IDLE);
          data_l_d[STAT_OVF]   = ovf_q;
          data_l_d[15:8]       = count8;
        end
        REG_DIV: data_l_d[15:0] = div_q;
        default: data_l_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ovf_q    <= 1'b0;
      div_q    <= DEFAULT_DIV;
      data_l_q <= '0;
    end else begin
      ovf_q    <= ovf_d;
      div_q    <= div_d;
      data_l_q <= data_l_d;
    end
  end

  // Serialiser: the timer runs bdiv-1 down to 0 in every non-idle state; txd lags state by one cycle.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bdiv_d   = bdiv_q;
    bitcnt_d = bitcnt_q;
    byte_d   = byte_q;
    fifo_pop = 1'b0;

    if (state_q != ST_IDLE) begin
      timer_d = (timer_q == '0) ? bdiv_q - 16'd1 : timer_q - 16'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          byte_d   = fifo_rdata;
          bdiv_d   = div_q;
          timer_d  = div_q - 16'd1;
          bitcnt_d = '0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (timer_q == '0) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (timer_q == '0) begin
          if (bitcnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (timer_q == '0) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (timer_q == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_q)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = byte_q[bitcnt_q];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd_d = ^byte_q;
`endif
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      bdiv_q   <= DEFAULT_DIV;
      bitcnt_q <= '0;
      byte_q   <= '0;
      txd_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bdiv_q   <= bdiv_d;
      bitcnt_q <= bitcnt_d;
      byte_q   <= byte_d;
      txd_q    <= txd_d;
    end
  end

  assign dm_data_l_o = data_l_q;
  assign uart_txd_o  = txd_q;

endmodule

// File: tb/tb_rv_uart_tx.sv
// Self-checking bench for rv_uart_tx: expected line waveforms come from a frame-level model of the UART rules.
module tb_rv_uart_tx;

  localparam logic [31:0] BASE  = 32'h0010_0000;
  localparam logic [31:0] A_TX  = BASE + 32'h0;
  localparam logic [31:0] A_ST  = BASE + 32'h4;
  localparam logic [31:0] A_DIV = BASE + 32'h8;
  localparam logic [31:0] A_RSV = BASE + 32'hC;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [31:0] dm_addr_i = '0;
  logic [31:0] dm_data_s_i = '0;
  logic [3:0]  dm_data_select_i = '0;
  logic        dm_write_i = 1'b0;
  logic [31:0] dm_data_l_o;
  logic        uart_txd_o;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic exp_q[$];
  logic obs_q[$];
  int   busy_cnt;

  rv_uart_tx dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .dm_addr_i        (dm_addr_i),
    .dm_data_s_i      (dm_data_s_i),
    .dm_data_select_i (dm_data_select_i),
    .dm_write_i       (dm_write_i),
    .dm_data_l_o      (dm_data_l_o),
    .uart_txd_o       (uart_txd_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic do_reset();
    rst_n_i = 1'b0;
    dm_write_i = 1'b0;
    dm_addr_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    dm_addr_i = a; dm_data_s_i = d; dm_data_select_i = s; dm_write_i = 1'b1;
    @(posedge clk_i); #1;
    dm_write_i = 1'b0; dm_data_select_i = '0; dm_addr_i = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    dm_addr_i = a; dm_write_i = 1'b0;
    @(posedge clk_i); #1;
    d = dm_data_l_o;
    dm_addr_i = '0;
  endtask

  // Reference frame: start 0, data LSB first, optional even parity, stop 1; each bit held div cycles.
  task automatic model_frame(input logic [7:0] b, input int div);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back(^b);
`endif
    bits.push_back(1'b1);
    foreach (bits[i]) repeat (div) exp_q.push_back(bits[i]);
  endtask

  task automatic capture(input int n);
    obs_q.delete();
    busy_cnt = 0;
    repeat (n) begin
      @(posedge clk_i); #1;
      obs_q.push_back(uart_txd_o);
      if (dm_data_l_o[2] === 1'b1) busy_cnt++;
    end
  endtask

  // obs_q[i] is matched against exp_q[i+off]; past the model the line must idle high.
  function automatic int wave_mismatch(input int off);
    int m = 0;
    logic e;
    for (int i = 0; i < obs_q.size(); i++) begin
      e = (i + off < exp_q.size()) ? exp_q[i + off] : 1'b1;
      if (obs_q[i] !== e) m++;
    end
    return m;
  endfunction

  task automatic test_reset();
    logic [31:0] rd;
    chk_cnt++;
    if (uart_txd_o !== 1'b1) $display("FAIL reset_txd: got %b want 1", uart_txd_o);
    else pass_cnt++;
    chk_cnt++;
    if (dm_data_l_o !== 32'h0) $display("FAIL reset_load: got %h want 0", dm_data_l_o);
    else pass_cnt++;
    bus_read(A_ST, rd);
    chk_cnt++;
    if (rd !== 32'h0000_0002) $display("FAIL reset_status: got %h want 00000002", rd);
    else pass_cnt++;
    bus_read(A_DIV, rd);
    chk_cnt++;
    if (rd !== 32'd868) $display("FAIL reset_div: got %0d want 868", rd);
    else pass_cnt++;
    bus_read(A_TX, rd);
    chk_cnt++;
    if (rd !== 32'h0) $display("FAIL txdata_read: got %h want 0", rd);
    else pass_cnt++;
  endtask

  task automatic test_basic_frame();
    logic [31:0] rd;
    int mm;
    bus_write(A_DIV, 32'd4, 4'hF);
    bus_write(A_TX, 32'h55, 4'h1);
    dm_addr_i = A_ST;
    exp_q.delete();
    exp_q.push_back(1'b1);
    model_frame(8'h55, 4);
    capture(60);
    chk_cnt++;
    if (obs_q[0] !== 1'b1 || obs_q[1] !== 1'b0)
      $display("FAIL start_latency: got N+1=%b N+2=%b want 1,0", obs_q[0], obs_q[1]);
    else pass_cnt++;
    mm = wave_mismatch(0);
    chk_cnt++;
    if (mm != 0) $display("FAIL frame_55: got %0d bad cycles want 0", mm);
    else pass_cnt++;
    chk_cnt++;
    if (busy_cnt != FB * 4) $display("FAIL busy_len: got %0d want %0d", busy_cnt, FB * 4);
    else pass_cnt++;
    bus_read(A_ST, rd);
    chk_cnt++;
    if (rd !== 32'h0000_0002) $display("FAIL status_after: got %h want 00000002", rd);
    else pass_cnt++;
  endtask

  task automatic test_random_frames();
    int mm, div;
    logic [7:0] b;
    for (int it = 0; it < 4; it++) begin
      div = $urandom_range(6, 2);
      b = 8'($urandom);
      bus_write(A_DIV, 32'(div), 4'hF);
      bus_write(A_TX, {24'h0, b}, 4'h1);
      exp_q.delete();
      exp_q.push_back(1'b1);
      model_frame(b, div);
      capture(FB * div + 6);
      mm = wave_mismatch(0);
      chk_cnt++;
      if (mm != 0) $display("FAIL rand_frame: byte %h div %0d got %0d bad cycles want 0", b, div, mm);
      else pass_cnt++;
    end
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    do_reset();
    for (int i = 0; i < 17; i++) bus_write(A_TX, $urandom, 4'h1);
    bus_read(A_ST, rd);
    chk_cnt++;
    if (rd !== 32'h0000_1005) $display("FAIL fill_16: got %h want 00001005", rd);
    else pass_cnt++;
    bus_write(A_TX, 32'hA5, 4'h1);
    bus_read(A_ST, rd);
    chk_cnt++;
    if (rd !== 32'h0000_100D) $display("FAIL overflow_set: got %h want 0000100d", rd);
    else pass_cnt++;
    bus_write(A_ST, 32'h8, 4'h1);
    bus_read(A_ST, rd);
    chk_cnt++;
    if (rd !== 32'h0000_1005) $display("FAIL overflow_clr: got %h want 00001005", rd);
    else pass_cnt++;
    bus_read(A_RSV, rd);
    chk_cnt++;
    if (rd !== 32'h0) $display("FAIL reserved_read: got %h want 0", rd);
    else pass_cnt++;
    bus_read(BASE + 32'h14, rd);
    chk_cnt++;
    if (rd !== 32'h0) $display("FAIL outside_read: got %h want 0", rd);
    else pass_cnt++;
  endtask

  task automatic test_div_min();
    logic [31:0] rd;
    int mm;
    do_reset();
    bus_write(A_DIV, 32'd0, 4'hF);
    bus_read(A_DIV, rd);
    chk_cnt++;
    if (rd !== 32'd1) $display("FAIL div_zero: got %0d want 1", rd);
    else pass_cnt++;
    bus_write(A_TX, 32'hFF, 4'h1);
    exp_q.delete();
    exp_q.push_back(1'b1);
    model_frame(8'hFF, 1);
    capture(20);
    mm = wave_mismatch(0);
    chk_cnt++;
    if (mm != 0) $display("FAIL frame_div1: got %0d bad cycles want 0", mm);
    else pass_cnt++;
    bus_write(A_DIV, 32'hABCD_0103, 4'hF);
    bus_read(A_DIV, rd);
    chk_cnt++;
    if (rd !== 32'h0000_0103) $display("FAIL div_16b: got %h want 00000103", rd);
    else pass_cnt++;
  endtask

  task automatic test_div_change();
    int mm;
    logic [7:0] a, b;
    a = 8'($urandom);
    b = 8'($urandom);
    bus_write(A_DIV, 32'd4, 4'hF);
    bus_write(A_TX, {24'h0, a}, 4'h1);
    bus_write(A_TX, {24'h0, b}, 4'h1);
    bus_write(A_DIV, 32'd8, 4'hF);
    exp_q.delete();
    exp_q.push_back(1'b1);
    model_frame(a, 4);
    exp_q.push_back(1'b1);
    model_frame(b, 8);
    capture(FB * 12 + 20);
    mm = wave_mismatch(2);
    chk_cnt++;
    if (mm != 0) $display("FAIL div_change: bytes %h %h got %0d bad cycles want 0", a, b, mm);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] rd;
    int lows;
    bus_write(A_DIV, 32'd4, 4'hF);
    for (int i = 0; i < 4; i++) bus_write(A_TX, 32'h00, 4'h1);
    repeat (11) @(posedge clk_i);
    #1;
    chk_cnt++;
    if (uart_txd_o !== 1'b0) $display("FAIL mid_data_low: got %b want 0", uart_txd_o);
    else pass_cnt++;
    rst_n_i = 1'b0;
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    chk_cnt++;
    if (uart_txd_o !== 1'b1) $display("FAIL reset_abort_txd: got %b want 1", uart_txd_o);
    else pass_cnt++;
    bus_read(A_ST, rd);
    chk_cnt++;
    if (rd !== 32'h0000_0002) $display("FAIL reset_abort_status: got %h want 00000002", rd);
    else pass_cnt++;
    bus_read(A_DIV, rd);
    chk_cnt++;
    if (rd !== 32'd868) $display("FAIL reset_abort_div: got %0d want 868", rd);
    else pass_cnt++;
    capture(100);
    lows = 0;
    foreach (obs_q[i]) if (obs_q[i] !== 1'b1) lows++;
    chk_cnt++;
    if (lows != 0) $display("FAIL no_frames_after_reset: got %0d non-idle cycles want 0", lows);
    else pass_cnt++;
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int mm;
    logic [7:0] vals [2];
    logic pexp [2];
    vals[0] = 8'h07; pexp[0] = 1'b1;
    vals[1] = 8'h03; pexp[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus_write(A_DIV, 32'd2, 4'hF);
      bus_write(A_TX, {24'h0, vals[k]}, 4'h1);
      exp_q.delete();
      exp_q.push_back(1'b1);
      model_frame(vals[k], 2);
      capture(30);
      chk_cnt++;
      if (obs_q[1 + 9 * 2] !== pexp[k])
        $display("FAIL parity_bit: byte %h got %b want %b", vals[k], obs_q[1 + 9 * 2], pexp[k]);
      else pass_cnt++;
      mm = wave_mismatch(0);
      chk_cnt++;
      if (mm != 0) $display("FAIL parity_frame: byte %h got %0d bad cycles want 0", vals[k], mm);
      else pass_cnt++;
    end
  endtask
`endif

  initial begin
    do_reset();
    test_reset();
    test_basic_frame();
    test_random_frames();
    test_div_change();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    test_overflow();
    test_div_min();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
